mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter XLEN, default 32, sets operand, HI and LO width; legal values are even integers >= 8.
REQ-002 Parameter CNT_W, default $clog2(XLEN+1), sets the iteration counter width.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is a synchronous, active-high reset.
REQ-005 Port start  input  1  requests a new operation; it is sampled only in IDLE.
REQ-006 Port op  input  2  selects the operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-007 Port a, b  input  XLEN  are operand A (multiplicand/dividend) and operand B (multiplier/divisor).
REQ-008 Port flush  input  1  aborts any in-flight operation.
REQ-009 Port mthi, mtlo  input  1 each  are direct write strobes for HI and LO, taking data from a.
REQ-010 Port busy  output  1  is high while an operation is in flight; the hazard unit stalls MFHI/MFLO and a new mult/div on it.
REQ-011 Port done  output  1  is a one-cycle pulse after HI/LO receive a result.
REQ-012 Port hi, lo  output  XLEN  are the architectural HI/LO registers, driven directly from flops.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FIX.
REQ-014 In IDLE with start=1 and flush=0, the block SHALL latch the operand magnitudes (two's-complement absolute values for DIV/MULT, raw values for DIVU/MULTU), latch the result signs, clear the counter and enter RUN.
REQ-015 RUN SHALL perform one radix-2 step per cycle for exactly XLEN cycles: shift-add for multiply, restoring shift-subtract for divide, using a 2*XLEN accumulator.
REQ-016 FIX SHALL last one cycle and perform the sign correction: the product is negated if the signs differ, the quotient is negated if the signs differ, and the remainder takes the sign of the dividend. HI/LO SHALL be written at the end of FIX.
REQ-017 Result mapping: multiply gives HI=product[2XLEN-1:XLEN] and LO=product[XLEN-1:0]; divide gives LO=quotient and HI=remainder.
REQ-018 Latency: if start is sampled at edge E0, HI/LO update at edge E0+XLEN+1 and done is high for the following cycle.
REQ-019 busy SHALL be 1 in RUN and FIX, otherwise 0; done SHALL never be high while busy=1.
REQ-020 A start arriving while busy=1 SHALL be ignored, with no queueing.
REQ-021 Divide by zero SHALL complete with normal latency and return LO=all ones and HI=a; for DIV, HI holds the original signed a.
REQ-022 DIV of the most negative value by -1 SHALL return LO=most negative value and HI=0, with no exception.
REQ-023 flush=1 in any state SHALL force IDLE at the next edge, leave HI/LO unchanged and suppress done; if flush and start are both 1 in IDLE, flush wins.
REQ-024 mthi/mtlo SHALL write HI/LO only in IDLE with start=0; they are ignored while busy or when start is accepted in the same cycle.
REQ-025 A result written at the end of FIX SHALL override a same-cycle mthi/mtlo.

Reset
REQ-026 When rst=1 at an edge, the block SHALL enter IDLE and clear HI, LO, the accumulator and the counter to 0; busy=0 and done=0 from the next cycle.
REQ-027 Reset SHALL take priority over flush, start and mthi/mtlo, and SHALL abort an in-flight operation with no done.

Configuration
REQ-028 Macro MDU_DIV_EN compiles in the divide datapath.
REQ-029 With MDU_DIV_EN defined, all four operations SHALL behave as specified above.
REQ-030 Without MDU_DIV_EN, DIV/DIVU SHALL be accepted and complete in the same XLEN+1 cycles with HI/LO unchanged, done pulsed, and no subtractor synthesised.

Structure
REQ-031 Package mdu_pkg SHALL hold the op encoding constants (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU) and the FSM state enum.
REQ-032 One sub-module, mdu_signfix, is natural: it is a combinational absolute-value/conditional-negate helper, instantiated for the operands and the results.
REQ-033 The iteration loop, counter and FSM SHALL stay in mdu_iter.

Verification (XLEN=32)
REQ-034 MULT with a=0xFFFFFFFD (-3) and b=7, start at E0 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB at E0+33; done high one cycle; busy high for exactly 33 cycles.
REQ-035 DIV with a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU with a=7, b=2 -> LO=3, HI=1.
REQ-036 DIVU with a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234; DIV with a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 Flush at cycle 10 of a MULT with HI/LO preloaded via mthi=0xA, mtlo=0xB -> HI=0xA, LO=0xB, no done, busy=0 next cycle; then a new start is accepted.
REQ-038 start and mthi while busy -> both ignored and the result is unaffected; rst mid-RUN -> HI=LO=0, busy=0, no done.
REQ-039 Build without MDU_DIV_EN, DIV with a=9, b=3 -> HI/LO unchanged, done at E0+33.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM state type and op-decode helpers for the iterative mult/div unit.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Combinational conditional two's-complement negate: absolute value on operands, sign restore on results.
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_dat,
  input  logic         neg,
  output logic [W-1:0] out_dat
);

  assign out_dat = neg ? (~in_dat + W'(1)) : in_dat;

endmodule

// File: rtl/mdu_iter.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO; result XLEN+1 cycles after start, new start ignored while busy.
// Divide datapath compiled in only with `MDU_DIV_EN; otherwise divides time out with HI/LO unchanged.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]    opd_q, opd_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic [XLEN-1:0]    hi_q, hi_d;
  logic [XLEN-1:0]    lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [XLEN-1:0]    mag_a, mag_b;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN:0]      mul_sum;
  logic [2*XLEN-1:0]  mul_nxt;

  mdu_signfix #(.W(XLEN)) u_fix_a (
    .in_dat (a),
    .neg    (op_is_signed(op) && a[XLEN-1]),
    .out_dat(mag_a)
  );

  mdu_signfix #(.W(XLEN)) u_fix_b (
    .in_dat (b),
    .neg    (op_is_signed(op) && b[XLEN-1]),
    .out_dat(mag_b)
  );

  mdu_signfix #(.W(2*XLEN)) u_fix_prod (
    .in_dat (acc_q),
    .neg    (neg_q),
    .out_dat(prod)
  );

  // Multiplier sits in the low half and drains out as product bits shift in from the top.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
  assign mul_nxt = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

`ifdef MDU_DIV_EN
  logic               rneg_q, rneg_d;
  logic               bzero_q, bzero_d;
  logic [XLEN-1:0]    a_q, a_d;
  logic [XLEN:0]      rem_sh;
  logic [XLEN:0]      trial;
  logic [2*XLEN-1:0]  div_nxt;
  logic [XLEN-1:0]    quo, rem;

  // Restoring step: quotient bits enter at the bottom, partial remainder lives in the top half.
  assign rem_sh  = acc_q[2*XLEN-1:XLEN-1];
  assign trial   = rem_sh - {1'b0, opd_q};
  assign div_nxt = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  mdu_signfix #(.W(XLEN)) u_fix_quo (
    .in_dat (acc_q[XLEN-1:0]),
    .neg    (neg_q),
    .out_dat(quo)
  );

  mdu_signfix #(.W(XLEN)) u_fix_rem (
    .in_dat (acc_q[2*XLEN-1:XLEN]),
    .neg    (rneg_q),
    .out_dat(rem)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MDU_DIV_EN
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    a_d     = a_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          busy_d  = 1'b1;
          div_d   = op_is_div(op);
          neg_d   = op_is_signed(op) && (a[XLEN-1] ^ b[XLEN-1]);
          if (op_is_div(op)) begin
            acc_d = {{XLEN{1'b0}}, mag_a};
            opd_d = mag_b;
          end else begin
            acc_d = {{XLEN{1'b0}}, mag_b};
            opd_d = mag_a;
          end
`ifdef MDU_DIV_EN
          rneg_d  = op_is_signed(op) && a[XLEN-1];
          bzero_d = (b == '0);
          a_d     = a;
`endif
        end else if (!start) begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef MDU_DIV_EN
        acc_d = div_q ? div_nxt : mul_nxt;
`else
        acc_d = div_q ? acc_q : mul_nxt;
`endif
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!div_q) begin
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end
`ifdef MDU_DIV_EN
        else if (bzero_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Flush discards whatever this cycle would have done to HI/LO.
    if (flush) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      a_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MDU_DIV_EN
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      a_q     <= a_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized self-checking bench for mdu_iter (XLEN=32) against an arithmetic HI/LO reference model.
module tb_mdu_iter;

  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [XL-1:0] a = '0;
  logic [XL-1:0] b = '0;
  logic          flush = 1'b0;
  logic          mthi = 1'b0;
  logic          mtlo = 1'b0;
  logic          busy, done;
  logic [XL-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [XL-1:0] exp_hi = '0;
  logic [XL-1:0] exp_lo = '0;

  mdu_iter #(.XLEN(XL)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .mthi (mthi),
    .mtlo (mtlo),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // Architectural result of one operation given the HI/LO held before it.
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] ph, input logic [31:0] pl,
                                 output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, sp;
    longint unsigned up;
    h = ph;
    l = pl;
    case (o)
      2'd0: begin
        sx = $signed(x);
        sy = $signed(y);
        sp = sx * sy;
        h = sp[63:32];
        l = sp[31:0];
      end
      2'd1: begin
        up = {32'd0, x} * {32'd0, y};
        h = up[63:32];
        l = up[31:0];
      end
`ifdef MDU_DIV_EN
      2'd2: begin
        if (y == 0) begin
          h = x;
          l = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          h = 32'd0;
          l = 32'h8000_0000;
        end else begin
          h = $signed(x) % $signed(y);
          l = $signed(x) / $signed(y);
        end
      end
      2'd3: begin
        if (y == 0) begin
          h = x;
          l = 32'hFFFF_FFFF;
        end else begin
          h = x % y;
          l = x / y;
        end
      end
`endif
      default: ;
    endcase
  endfunction

  // Starts an op at the current negedge; returns at the negedge where done is seen.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit disturb);
    int k;
    int busy_cnt;
    bit seen;
    logic [31:0] old_hi, old_lo;
    old_hi = exp_hi;
    old_lo = exp_lo;
    ref_op(o, x, y, old_hi, old_lo, exp_hi, exp_lo);
    op = o; a = x; b = y; start = 1'b1;
    k = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", name, busy, done);
        end
      end
      if (disturb && k == 5) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      end
      if (disturb && k == 6) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      if (k == XL + 1) begin
        checks++;
        if (hi !== old_hi || lo !== old_lo) begin
          errors++;
          $display("FAIL %s early_update: hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, old_hi, old_lo);
        end
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", name, k);
    end else begin
      checks++;
      if (k != XL + 2 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s latency: done at cycle %0d busy=%b, want cycle %0d busy=0", name, k, busy, XL + 2);
      end
      checks++;
      if (busy_cnt != XL + 1) begin
        errors++;
        $display("FAIL %s busy_len: %0d cycles, want %0d", name, busy_cnt, XL + 1);
      end
      checks++;
      if (hi !== exp_hi || lo !== exp_lo) begin
        errors++;
        $display("FAIL %s result op=%0d a=%h b=%h: hi=%h lo=%h, want hi=%h lo=%h",
                 name, o, x, y, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, want all zero", hi, lo, busy, done);
    end
  endtask

  task automatic test_mthi_mtlo();
    a = 32'hA; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0; a = 32'hB; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    exp_hi = 32'hA;
    exp_lo = 32'hB;
    checks++;
    if (hi !== 32'hA || lo !== 32'hB) begin
      errors++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h, want hi=0000000a lo=0000000b", hi, lo);
    end
    // start+flush together: flush wins, and start=1 blocks the move.
    a = 32'hC; mthi = 1'b1; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    mthi = 1'b0; start = 1'b0; flush = 1'b0;
    checks++;
    if (hi !== 32'hA || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_wins: hi=%h busy=%b, want hi=0000000a busy=0", hi, busy);
    end
  endtask

  task automatic test_directed();
    run_op("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_neg3x7_lit: hi=%h lo=%h, want ffffffff ffffffeb", hi, lo);
    end
`ifdef MDU_DIV_EN
    run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_m7_2_lit: hi=%h lo=%h, want ffffffff fffffffd", hi, lo);
    end
    run_op("divu_7_2", 2'd3, 32'd7, 32'd2, 1'b0);
    checks++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      errors++;
      $display("FAIL divu_7_2_lit: hi=%h lo=%h, want 00000001 00000003", hi, lo);
    end
    run_op("divu_by0", 2'd3, 32'h1234, 32'd0, 1'b0);
    checks++;
    if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL divu_by0_lit: hi=%h lo=%h, want 00001234 ffffffff", hi, lo);
    end
    run_op("div_min_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_min_m1_lit: hi=%h lo=%h, want 00000000 80000000", hi, lo);
    end
    run_op("div_neg_by0", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
`else
    run_op("div_disabled", 2'd2, 32'd9, 32'd3, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL div_disabled_keep: hi=%h lo=%h, want ffffffff ffffffeb", hi, lo);
    end
`endif
  endtask

  task automatic test_flush();
    bit seen_done;
    a = 32'hA; mthi = 1'b1; mtlo = 1'b0;
    @(negedge clk);
    a = 32'hB; mthi = 1'b0; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    exp_hi = 32'hA;
    exp_lo = 32'hB;
    op = 2'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'hA || lo !== 32'hB) begin
      errors++;
      $display("FAIL flush_state: busy=%b hi=%h lo=%h, want 0 0000000a 0000000b", busy, hi, lo);
    end
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || hi !== 32'hA || lo !== 32'hB) begin
      errors++;
      $display("FAIL flush_no_done: done_seen=%b hi=%h lo=%h, want 0 0000000a 0000000b", seen_done, hi, lo);
    end
    run_op("after_flush", 2'd1, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_busy_ignore();
    run_op("busy_ignore_mult", 2'd0, $urandom, $urandom, 1'b1);
    run_op("busy_ignore_multu", 2'd1, $urandom, $urandom, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    op = 2'd1; a = 32'hDEAD_BEEF; b = 32'h0000_1001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1; flush = 1'b1; mthi = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; mthi = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL reset_mid_no_done: done seen=%b, want 0", seen_done);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_0", 2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    run_op("b2b_1", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("b2b_2", 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = 32'($urandom_range(0, 300)) - 32'd150; y = 32'($urandom_range(1, 20)); end
        default: ;
      endcase
      run_op("random", o, x, y, (i % 8) == 3);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_directed();
    test_flush();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
